// File: rtl/add_32_arbiter_pkg.sv
// Shared definitions for the add_32 arbiter.
// Holds the operand width and the controller state encoding.
// It is imported by the arbiter top and its round-robin picker.
package add_32_arbiter_pkg;

    localparam int unsigned OpW = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } arb_state_e;

endpackage

// File: rtl/add_32.sv
// 32-bit combinational adder: c = a + b. The carry out is discarded.
// Ports:
//   a, b  operands
//   c     sum, modulo 2^32
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    assign c = a + b;

endmodule

// File: rtl/add_32_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It scans req upward from ptr and wraps modulo N_REQ.
// Ports:
//   req   per-requester request bits
//   ptr   first index to consider (always < N_REQ)
//   any   at least one request is pending
//   gidx  index of the winning requester (0 when any is low)
module add_32_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] gidx
);

    logic             found;
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        any      = |req;
        gidx     = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // ptr + i < 2*N_REQ, so one subtraction is enough for the wrap.
            cand = 32'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                gidx  = cand_idx;
            end
        end
    end

endmodule

// File: rtl/add_32_arbiter.sv
// Round-robin arbiter that time-shares one add_32 among N_REQ requesters.
// IDLE latches the winner's operands, EXEC registers the sum, and DONE pulses done.
// Optional macro ADD_32_ARB_OVF_EN adds the registered signed-overflow output ovf.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req          per-requester level request, held until its done
//   a_in, b_in   packed operands; slice k = [32k+31:32k]
//   grant        one-hot, marks the requester being served (EXEC and DONE)
//   done         one-cycle pulse in DONE for the served requester
//   result       registered sum, held until the next operation completes
//   busy         high in EXEC and DONE
//   ovf          (optional) signed overflow of the last result
module add_32_arbiter
    import add_32_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [OpW*N_REQ-1:0] a_in,
    input  logic [OpW*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [OpW-1:0]     result,
    output logic               busy
`ifdef ADD_32_ARB_OVF_EN
   ,output logic               ovf
`endif
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q;
    logic [OpW-1:0]   op_a_q, op_b_q;
    logic [OpW-1:0]   result_q;
    logic [OpW-1:0]   sum;
    logic [OpW-1:0]   sel_a, sel_b;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    add_32_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .any  (pick_any),
        .gidx (pick_idx)
    );

    add_32 u_add_32 (
        .a (op_a_q),
        .b (op_b_q),
        .c (sum)
    );

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_a = a_in[k*OpW +: OpW];
                sel_b = b_in[k*OpW +: OpW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant   = '0;
        done    = '0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                grant[gidx_q] = 1'b1;
                busy          = 1'b1;
                state_d       = StDone;
            end
            StDone: begin
                grant[gidx_q] = 1'b1;
                done[gidx_q]  = 1'b1;
                busy          = 1'b1;
                state_d       = StIdle;
                ptr_d         = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            gidx_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
`ifdef ADD_32_ARB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == StIdle && pick_any) begin
                op_a_q <= sel_a;
                op_b_q <= sel_b;
                gidx_q <= pick_idx;
            end
            if (state_q == StExec) begin
                result_q <= sum;
`ifdef ADD_32_ARB_OVF_EN
                ovf      <= (op_a_q[OpW-1] == op_b_q[OpW-1]) && (sum[OpW-1] != op_a_q[OpW-1]);
`endif
            end
        end
    end

    assign result = result_q;

endmodule

// File: doc/add_32_arbiter.md
Name: add_32_arbiter

Overview:
- Shares one add_32 instance (32-bit combinational adder, c = a + b, no carry-out) among N_REQ requesters.
- Round-robin arbitration, registered operands and result, per-requester done pulse.
- Sits between ALU-side users (PC increment, address calc, test sequencer) and the single physical adder, so they time-multiplex it.

Parameters:
- N_REQ, 4, number of requesters (2..4 supported).
- IDX_W, 2, width of the grant index; must satisfy 2**IDX_W >= N_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; level, held until own done.
- a_in  in  32*N_REQ  packed operand A; slice k = a_in[32k+31:32k].
- b_in  in  32*N_REQ  packed operand B, same packing.
- grant  out  N_REQ  one-hot, marks the requester being served.
- done  out  N_REQ  one-cycle pulse, result valid for that requester.
- result  out  32  registered sum, holds until the next DONE.
- busy  out  1  high in EXEC and DONE.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset values: state=IDLE, ptr=0, grant=0, done=0, result=0, busy=0, op_a=op_b=0.
- FSM has three states, IDLE / EXEC / DONE, with no other transitions:
  - IDLE: if req != 0, select winner g by round-robin, scanning from ptr upward with wrap modulo N_REQ. Latch op_a <= a_in slice g, op_b <= b_in slice g, gidx <= g, then go to EXEC. If req == 0, stay in IDLE.
  - EXEC: grant[gidx]=1, busy=1. At the clock edge, result <= op_a + op_b (through add_32) and state goes to DONE.
  - DONE: grant[gidx]=1, done[gidx]=1, busy=1. At the clock edge, ptr <= (gidx+1) mod N_REQ and state goes to IDLE.
- Latency: request sampled at edge n; done is high in cycle n+2. Throughput is 1 operation per 3 cycles.
- Handshake:
  - Requester keeps req and its operands stable until it sees its done.
  - Requester must drop req in the cycle after done, or re-request with new operands.
  - Operands change only after the IDLE latch; later changes are ignored.
- Arithmetic: 32-bit modulo 2^32; carry out is discarded (0xFFFFFFFF+1 = 0).
- req of an unselected requester is not lost; it wins on a later IDLE scan.
- Requester k holding req continuously waits at most N_REQ-1 other operations.
- req changes during EXEC/DONE have no effect on the current operation.
- rst asserted in any state returns the block to the reset values at that edge. The in-flight operation is discarded: no done for it.
- Slices of unused requester indices (k >= N_REQ) do not exist; the scan only covers 0..N_REQ-1.

Optional Feature:
- Macro: ADD_32_ARB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), registered with result.
  - ovf = signed overflow = (op_a[31]==op_b[31]) && (sum[31]!=op_a[31]).
  - ovf resets to 0 and is valid in DONE.
- Undefined: no ovf port and no overflow logic.

Decomposition:
- Shared header add_32_arb_defs.vh, the codebase's package equivalent, holds:
  - state encodings S_IDLE=2'd0, S_EXEC=2'd1, S_DONE=2'd2;
  - operand width constant 32.
- Natural sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req, ptr. Outputs: any, gidx.
  - Verified standalone.
- The adder itself is the existing add_32, instantiated once.

Test Plan:
- Single request, rst then req=0001, a0=1, b0=7 -> grant=0001 in cycles n+1..n+2, done=0001 only in cycle n+2, result=8, busy low again in n+3.
- Wrap: req0 with a0=0xFFFFFFFF, b0=1 -> result=0x00000000. With ADD_32_ARB_OVF_EN, ovf=0. Then a0=0x7FFFFFFF, b0=1 -> result=0x80000000, ovf=1.
- Contention: req=1111 simultaneously from reset, requester k supplies a=k, b=10 -> done pulses in order 0,1,2,3, 3 cycles apart, results 10,11,12,13.
- Fairness: req0 and req2 held continuously, each re-requesting right after its done -> grants alternate 0,2,0,2; neither is served twice in a row.
- Reset mid-op: req1 granted, rst pulsed during EXEC -> no done at any time, result=0, grant=0, ptr=0. The next req=0010 is served normally 2 cycles after its sampling edge.
- Operand change during EXEC (a1 from 5 to 9, b1=1) -> result=6, proving operands were latched in IDLE.
